// File: rtl/hex_scan_ctrl.sv
// Scan controller for a 4-digit common-anode hex 7-segment display.
// It shows one digit per slot with a dark lead-in, and loads the value through a shadow register committed at frame wrap.
module hex_scan_ctrl #(
   parameter int DIGIT_CYC = 50000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic [3:0]  point_in,
   input  logic [3:0]  blank_in,
   input  logic        load,
   output logic        load_ack,
   output logic        frame_done,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam int CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYC - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_dig;
   logic [15:0]   r_sh_data;
   logic [3:0]    r_sh_point;
   logic [3:0]    r_sh_blank;
   logic [15:0]   r_act_data;
   logic [3:0]    r_act_point;
   logic [3:0]    r_act_blank;
   logic          r_pend;
   logic          r_ack;
   logic          r_fd;
   logic [3:0]    r_an;
   logic [7:0]    r_seg;

   logic          w_wrap;
   logic          w_fwrap;
   logic [3:0]    w_nib;
   logic          w_show;
   logic [3:0]    w_an;
   logic [7:0]    w_seg;

   // Hex nibble to active-low g..a pattern
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0:    p = 7'h40;
         4'h1:    p = 7'h79;
         4'h2:    p = 7'h24;
         4'h3:    p = 7'h30;
         4'h4:    p = 7'h19;
         4'h5:    p = 7'h12;
         4'h6:    p = 7'h02;
         4'h7:    p = 7'h78;
         4'h8:    p = 7'h00;
         4'h9:    p = 7'h10;
         4'hA:    p = 7'h08;
         4'hB:    p = 7'h03;
         4'hC:    p = 7'h46;
         4'hD:    p = 7'h21;
         4'hE:    p = 7'h06;
         4'hF:    p = 7'h0E;
         default: p = 7'h7F;
      endcase
      return p;
   endfunction

   // Slot/frame wrap detection and next display drive from the active register
   always_comb begin
      w_wrap  = (r_cnt == CNT_LAST);
      w_fwrap = w_wrap && (r_dig == 2'd3);
      case (r_dig)
         2'd0:    w_nib = r_act_data[3:0];
         2'd1:    w_nib = r_act_data[7:4];
         2'd2:    w_nib = r_act_data[11:8];
         2'd3:    w_nib = r_act_data[15:12];
         default: w_nib = 4'h0;
      endcase
      w_show = (r_cnt >= CNT_BLANK) && !r_act_blank[r_dig];
      if (w_show) begin
         w_an  = ~(4'b0001 << r_dig);
         w_seg = {~r_act_point[r_dig], hex7(w_nib)};
      end else begin
         w_an  = 4'hF;
         w_seg = 8'hFF;
      end
   end

   // Slot counter and digit index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= {CW{1'b0}};
         r_dig <= 2'd0;
      end else begin
         r_cnt <= w_wrap ? {CW{1'b0}} : r_cnt + CW'(1);
         if (w_wrap) begin
            r_dig <= r_dig + 2'd1;
         end
      end
   end

   // Shadow/active double buffer; a load coinciding with commit stays pending for the next frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh_data   <= 16'h0000;
         r_sh_point  <= 4'h0;
         r_sh_blank  <= 4'hF;
         r_act_data  <= 16'h0000;
         r_act_point <= 4'h0;
         r_act_blank <= 4'hF;
         r_pend      <= 1'b0;
      end else begin
         if (load) begin
            r_sh_data  <= data_in;
            r_sh_point <= point_in;
            r_sh_blank <= blank_in;
         end
         if (w_fwrap && r_pend) begin
            r_act_data  <= r_sh_data;
            r_act_point <= r_sh_point;
            r_act_blank <= r_sh_blank;
         end
         r_pend <= load | (r_pend & ~w_fwrap);
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ack <= 1'b0;
         r_fd  <= 1'b0;
         r_an  <= 4'hF;
         r_seg <= 8'hFF;
      end else begin
         r_ack <= w_fwrap & r_pend;
         r_fd  <= w_fwrap;
         r_an  <= w_an;
         r_seg <= w_seg;
      end
   end

   assign load_ack   = r_ack;
   assign frame_done = r_fd;
   assign an         = r_an;
   assign seg        = r_seg;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with DIGIT_CYC=8, BLANK_CYC=2 (32-cycle frame).
module tb_hex_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  point_in;
   logic [3:0]  blank_in;
   logic        load;
   logic        load_ack;
   logic        frame_done;
   logic [3:0]  an;
   logic [7:0]  seg;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [3:0] AN_EXP [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

   hex_scan_ctrl #(.DIGIT_CYC(8), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .point_in   (point_in),
      .blank_in   (blank_in),
      .load       (load),
      .load_ack   (load_ack),
      .frame_done (frame_done),
      .an         (an),
      .seg        (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one load strobe at the current negedge; returns one edge later.
   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      data_in  = d;
      point_in = p;
      blank_in = b;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   // Wait (bounded) for frame_done and check load_ack on that same cycle.
   task automatic wait_frame(input logic exp_ack, input string tag);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = frame_done;
      end
      check({tag, "_fd"}, {31'd0, seen}, 32'd1);
      check({tag, "_ack"}, {31'd0, load_ack}, {31'd0, exp_ack});
   endtask

   // Starting at a frame_done cycle, check every cycle of the next frame.
   task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [3:0] blk, input string tag);
      logic [7:0]  segs [4];
      logic [11:0] exp;
      segs = '{s0, s1, s2, s3};
      for (int s = 0; s < 4; s++) begin
         for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j < 2 || blk[s]) exp = 12'hFFF;
            else                 exp = {AN_EXP[s], segs[s]};
            check($sformatf("%s_d%0d_c%0d", tag, s, j), {20'd0, an, seg}, {20'd0, exp});
            check($sformatf("%s_fd_d%0d_c%0d", tag, s, j), {31'd0, frame_done},
                  {31'd0, (s == 3 && j == 7)});
         end
      end
   endtask

   // Run nf frames without loads: display dark, frame_done every 32 cycles, no ack.
   task automatic dark_frames(input int nf, input string tag);
      int bad_dark, bad_fd, bad_ack;
      bad_dark = 0;
      bad_fd   = 0;
      bad_ack  = 0;
      for (int n = 1; n <= nf * 32; n++) begin
         @(negedge clk);
         if ({an, seg} !== 12'hFFF) bad_dark++;
         if (frame_done !== ((n % 32) == 0)) bad_fd++;
         if (load_ack !== 1'b0) bad_ack++;
      end
      check({tag, "_dark"}, bad_dark, 32'd0);
      check({tag, "_fd_period"}, bad_fd, 32'd0);
      check({tag, "_no_ack"}, bad_ack, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      data_in  = 16'h0000;
      point_in = 4'h0;
      blank_in = 4'h0;
      load     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_seg", {24'd0, seg}, 32'hFF);
      check("rst_ack", {31'd0, load_ack}, 32'd0);
      check("rst_fd", {31'd0, frame_done}, 32'd0);
      rst = 1'b1;

      dark_frames(3, "idle");

      do_load(16'h1234, 4'b0100, 4'b0000);
      wait_frame(1'b1, "ld1234");
      check_frame(8'h99, 8'hB0, 8'h24, 8'hF9, 4'b0000, "f1234");

      do_load(16'hAAAA, 4'b0000, 4'b0000);
      repeat (5) @(negedge clk);
      do_load(16'hC0DE, 4'b0000, 4'b0000);
      wait_frame(1'b1, "ld2x");
      check_frame(8'h86, 8'hA1, 8'hC0, 8'hC6, 4'b0000, "fC0DE");
      check("single_ack", {31'd0, load_ack}, 32'd0);

      do_load(16'h0000, 4'b0000, 4'b0000);
      repeat (30) @(negedge clk);
      do_load(16'hFFFF, 4'b0000, 4'b0000);
      check("wrapld_fd", {31'd0, frame_done}, 32'd1);
      check("wrapld_ack1", {31'd0, load_ack}, 32'd1);
      check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000, "f0000");
      check("wrapld_ack2", {31'd0, load_ack}, 32'd1);
      check_frame(8'h8E, 8'h8E, 8'h8E, 8'h8E, 4'b0000, "fFFFF");
      check("wrapld_noack", {31'd0, load_ack}, 32'd0);

      do_load(16'h1234, 4'b0000, 4'b0010);
      wait_frame(1'b1, "ldblk");
      check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0010, "fblk");

      repeat (20) @(negedge clk);
      check("pre_rst_an", {28'd0, an}, 32'hB);
      #1 rst = 1'b0;
      #1;
      check("async_rst_an", {28'd0, an}, 32'hF);
      check("async_rst_seg", {24'd0, seg}, 32'hFF);
      repeat (2) @(negedge clk);
      check("hold_rst_fd", {31'd0, frame_done}, 32'd0);
      rst = 1'b1;
      dark_frames(2, "post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
